lpc_analysis_filter: RTL and testbench
======================================

// Module: lpc_analysis_filter
// PURPOSE
//  Downstream stage of LDR: 11-tap LPC inverse (whitening) FIR producing residual
//  e[n] = sum_{k=0..10} A_k * x[n-k] from the sample stream that feeds the correlation block.
//  A0..A10 from LDR are captured on its done strobe and double-buffered.
//  New coefficients take effect only at a frame boundary, so each frame is filtered with one coefficient set.
// PARAMETERS
//  FRAME_LEN  160  valid samples per frame (>=2); frame counter wraps at FRAME_LEN-1
//  COEF_FRAC  12   fractional bits of A_k (Q3.12 default); 1.0 = 1<<COEF_FRAC
// PORTS
//  clk          in   1      system clock, all state updates on posedge
//  rst          in   1      synchronous, active-high reset
//  x            in   16     signed input sample, qualified by v
//  v            in   1      input sample valid, one sample per cycle max
//  A0..A10      in   11x16  signed LPC coefficients from LDR, sampled only when done=1
//  done         in   1      LDR completion strobe; 1-cycle pulse, captures A0..A10
//  e            out  16     signed residual sample, saturated
//  vout         out  1      e valid
//  frame_start  out  1      high with vout for the residual of frame sample index 0
//  coef_pending out  1      shadow set captured, not yet applied
// BEHAVIOUR
//  Reset (rst=1 at posedge, any time, including mid-frame or mid-pipeline):
//   - e=0, vout=0, frame_start=0, coef_pending=0.
//   - Delay line x[n-1..n-10] = 0; frame count = 0; pipeline valids flushed.
//   - Active set = pass-through (A0=1<<COEF_FRAC, A1..A10=0); shadow = pass-through.
//  Delay line:
//   - Shifts only on cycles with v=1; bubbles (v=0) neither shift it nor advance the frame count.
//   - History is continuous across frame boundaries (no clearing).
//  Frame count:
//   - Increments per accepted sample, 0..FRAME_LEN-1, then wraps to 0.
//   - Boundary = v=1 and count==0.
//  Coefficient load:
//   - done=1: shadow <= A0..A10; coef_pending <= 1.
//   - done while already pending: shadow overwritten (latest wins).
//  Swap:
//   - At a boundary with coef_pending=1, that index-0 sample is the first filtered with the shadow set.
//   - Active <= shadow; coef_pending <= 0.
//   - done in the same cycle as a boundary: the swap uses the pre-capture shadow.
//     The new capture stays pending (coef_pending=1) for the next boundary.
//  Pipeline (fixed latency 4, one result per valid input, no stalls):
//   - S1: register x and the delay-line snapshot with the selected coefficients.
//   - S2: 11 signed 16x16 products (32b).
//   - S3: sign-extended adder tree to 36b accumulator, no overflow possible.
//   - S4: round half-up (add 1<<(COEF_FRAC-1), arithmetic shift right COEF_FRAC).
//     Then saturate to [-32768, 32767]; register e.
//   - vout and frame_start are v and (boundary) delayed by exactly 4 cycles.
//  e holds its last value when vout=0.
// STRUCTURE
//  Shared package lpc_pkg:
//   - SAMPLE_W=16, COEF_W=16, LPC_ORDER=10, PROD_W=32, ACC_W=36.
//   - Pass-through coefficient constant; coefficient-array typedef (LPC_ORDER+1 x COEF_W).
//   - Common to correlation, LDR and this block.
//  One sub-module: lpc_round_sat (ACC_W in, COEF_FRAC shift, round half-up, 16b saturate), reusable by LDR.
// TESTING
//  1 Reset, no load, x=1000 every cycle -> e=1000 with vout 4 cycles after each v; first vout has frame_start=1.
//  2 FRAME_LEN=16, ramp x=100*n, done at sample 10 with A0=4096, A1=-4096, rest 0.
//    -> samples 0..15 pass-through (e=100*n); from sample 16 on, e=100; coef_pending 1 from sample 11 to 16.
//  3 A0=32767, A1..A10=0, x=32767 -> e=32767; x=-32768 -> e=-32768 (saturation both rails).
//  4 A0=2048, x=3 -> e=2; x=-3 -> e=-1 (round half-up); x=1 -> e=1.
//  5 Two done pulses before a boundary (A1=-4096 then A1=+4096) -> the second set is applied.
//    done coincident with a boundary -> swap deferred one frame.
//  6 v toggling 1/0 pattern -> results equal to the gapless run.
//    rst mid-frame with pipeline full -> vout=0 next cycle, then pass-through, count restarts at 0.

Source files
------------

// File: rtl/lpc_pkg.sv
// LPC shared package: widths, coefficient types and helpers
// used by the correlation, Levinson-Durbin and analysis-filter blocks.
package lpc_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int COEF_W    = 16;
  localparam int LPC_ORDER = 10;
  localparam int PROD_W    = 32;
  localparam int ACC_W     = 36;
  localparam int NTAP      = LPC_ORDER + 1;
  localparam int COEF_FRAC_DEF = 12;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0]   coef_t;
  typedef logic signed [PROD_W-1:0]   prod_t;
  typedef logic signed [ACC_W-1:0]    acc_t;
  typedef coef_t coef_arr_t [NTAP];

  // Tap k of the pass-through (identity) coefficient set.
  function automatic coef_t pass_coef(input int k, input int frac);
    return (k == 0) ? coef_t'(1 << frac) : coef_t'(0);
  endfunction

endpackage

// File: rtl/lpc_analysis_filter_if.sv
// Analysis-filter bus: sample stream, LDR coefficient load
// and residual output bundled for one master and one slave.
interface lpc_analysis_filter_if;
  import lpc_pkg::*;

  sample_t x;
  logic    v;
  coef_t   A0, A1, A2, A3, A4, A5;
  coef_t   A6, A7, A8, A9, A10;
  logic    done;
  sample_t e;
  logic    vout;
  logic    frame_start;
  logic    coef_pending;

  modport master (
    output x, v, done,
    output A0, A1, A2, A3, A4, A5,
    output A6, A7, A8, A9, A10,
    input  e, vout, frame_start, coef_pending
  );

  modport slave (
    input  x, v, done,
    input  A0, A1, A2, A3, A4, A5,
    input  A6, A7, A8, A9, A10,
    output e, vout, frame_start, coef_pending
  );

endinterface

// File: rtl/lpc_round_sat.sv
// Round half-up an accumulator by FRAC bits, then
// saturate to a signed 16-bit sample.
module lpc_round_sat
  import lpc_pkg::*;
#(
  parameter int FRAC = COEF_FRAC_DEF
) (
  input  acc_t    acc,
  output sample_t y
);

  localparam acc_t HALF = acc_t'(1) << (FRAC - 1);

  acc_t rnd;
  acc_t shf;
  logic [ACC_W-SAMPLE_W:0] hi;

  // Headroom of 36b keeps the half-LSB add from wrapping.
  always_comb begin
    rnd = acc + HALF;
    shf = rnd >>> FRAC;
    hi  = shf[ACC_W-1:SAMPLE_W-1];
    if ((&hi) || (~|hi)) begin
      y = shf[SAMPLE_W-1:0];
    end else if (shf[ACC_W-1]) begin
      y = 16'sh8000;
    end else begin
      y = 16'sh7fff;
    end
  end

endmodule

// File: rtl/lpc_analysis_filter.sv
// 11-tap LPC whitening FIR with frame-aligned
// double-buffered coefficients and a 4-stage pipeline.
module lpc_analysis_filter
  import lpc_pkg::*;
#(
  parameter int FRAME_LEN = 160,
  parameter int COEF_FRAC = COEF_FRAC_DEF
) (
  input logic clk,
  input logic rst,
  lpc_analysis_filter_if.slave bus
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(FRAME_LEN - 1);

  coef_arr_t a_in;
  coef_arr_t active;
  coef_arr_t shadow;
  coef_arr_t sel;
  coef_arr_t s1_c;

  sample_t hist [LPC_ORDER];
  sample_t s1_x [NTAP];
  prod_t   prod [NTAP];

  acc_t    acc_sum;
  acc_t    acc;
  sample_t y;
  sample_t e;

  logic [CNT_W-1:0] cnt;
  logic pending;
  logic boundary;
  logic swap;

  logic s1_v, s2_v, s3_v, vout;
  logic s1_fs, s2_fs, s3_fs, fs;

  // Gather the LDR coefficient ports into one array.
  always_comb begin
    a_in[0]  = bus.A0;
    a_in[1]  = bus.A1;
    a_in[2]  = bus.A2;
    a_in[3]  = bus.A3;
    a_in[4]  = bus.A4;
    a_in[5]  = bus.A5;
    a_in[6]  = bus.A6;
    a_in[7]  = bus.A7;
    a_in[8]  = bus.A8;
    a_in[9]  = bus.A9;
    a_in[10] = bus.A10;
  end

  assign boundary = bus.v && (cnt == '0);
  assign swap     = boundary && pending;

  // The index-0 sample of a swapping frame already uses the shadow.
  always_comb begin
    for (int k = 0; k < NTAP; k++) begin
      sel[k] = swap ? shadow[k] : active[k];
    end
  end

  // Shadow capture on done, active swap at a pending boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      for (int k = 0; k < NTAP; k++) begin
        active[k] <= pass_coef(k, COEF_FRAC);
        shadow[k] <= pass_coef(k, COEF_FRAC);
      end
    end else begin
      if (swap) begin
        active <= shadow;
      end
      if (bus.done) begin
        shadow <= a_in;
      end
      if (bus.done) begin
        pending <= 1'b1;
      end else if (swap) begin
        pending <= 1'b0;
      end
    end
  end

  // Frame counter and sample history advance on valid samples only.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      for (int k = 0; k < LPC_ORDER; k++) begin
        hist[k] <= '0;
      end
    end else if (bus.v) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      hist[0] <= bus.x;
      for (int k = 1; k < LPC_ORDER; k++) begin
        hist[k] <= hist[k-1];
      end
    end
  end

  // S1 data: current sample, history snapshot, selected set.
  always_ff @(posedge clk) begin
    s1_x[0] <= bus.x;
    for (int k = 1; k < NTAP; k++) begin
      s1_x[k] <= hist[k-1];
    end
    s1_c <= sel;
  end

  // S2 data: eleven full-precision products.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NTAP; k++) begin
      prod[k] <= PROD_W'(s1_x[k]) * PROD_W'(s1_c[k]);
    end
  end

  // Sign-extended sum of the products; 36b cannot overflow.
  always_comb begin
    acc_sum = '0;
    for (int k = 0; k < NTAP; k++) begin
      acc_sum = acc_sum + ACC_W'(prod[k]);
    end
  end

  // S3 data: accumulator register.
  always_ff @(posedge clk) begin
    acc <= acc_sum;
  end

  lpc_round_sat #(
    .FRAC (COEF_FRAC)
  ) u_round_sat (
    .acc (acc),
    .y   (y)
  );

  // Valid and frame-start tags ride alongside the data stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      s3_v  <= 1'b0;
      vout  <= 1'b0;
      s1_fs <= 1'b0;
      s2_fs <= 1'b0;
      s3_fs <= 1'b0;
      fs    <= 1'b0;
    end else begin
      s1_v  <= bus.v;
      s2_v  <= s1_v;
      s3_v  <= s2_v;
      vout  <= s3_v;
      s1_fs <= boundary;
      s2_fs <= s1_fs;
      s3_fs <= s2_fs;
      fs    <= s3_fs;
    end
  end

  // S4: residual register, held between valid results.
  always_ff @(posedge clk) begin
    if (rst) begin
      e <= '0;
    end else if (s3_v) begin
      e <= y;
    end
  end

  assign bus.e            = e;
  assign bus.vout         = vout;
  assign bus.frame_start  = fs;
  assign bus.coef_pending = pending;

endmodule

// File: tb/tb_lpc_analysis_filter.sv
// Directed bench for lpc_analysis_filter: hand-computed
// residuals queued per sample, checked as they emerge.
module tb_lpc_analysis_filter;
  import lpc_pkg::*;

  localparam int FL = 16;

  typedef struct {
    int e;
    bit fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  int fidx = 0;
  string phase = "init";
  exp_t q[$];

  lpc_analysis_filter_if bus ();

  lpc_analysis_filter #(
    .FRAME_LEN (FL),
    .COEF_FRAC (12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s_%s got=%0d exp=%0d",
               phase, tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.done = 1'b0;
  endtask

  task automatic idle();
    bus.v = 1'b0;
    tick();
  endtask

  task automatic set_coef(input int a0, input int a1);
    bus.A0 = 16'(a0);
    bus.A1 = 16'(a1);
    bus.A2 = '0; bus.A3 = '0; bus.A4 = '0;
    bus.A5 = '0; bus.A6 = '0; bus.A7 = '0;
    bus.A8 = '0; bus.A9 = '0; bus.A10 = '0;
    bus.done = 1'b1;
  endtask

  task automatic send(input int xv, input int ev);
    exp_t t;
    t.e  = ev;
    t.fs = (fidx == 0);
    q.push_back(t);
    fidx = (fidx + 1) % FL;
    bus.x = 16'(xv);
    bus.v = 1'b1;
    tick();
    bus.v = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && q.size() > 0; i++) begin
      idle();
    end
    check("drain", q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.v = 1'b0;
    tick();
    rst = 1'b0;
    q.delete();
    fidx = 0;
    check("rst_vout", bus.vout, 0);
    check("rst_e", bus.e, 0);
    check("rst_fs", bus.frame_start, 0);
    check("rst_pend", bus.coef_pending, 0);
  endtask

  // Scoreboard: pop one expected residual per vout.
  always @(negedge clk) begin : mon
    exp_t t;
    if (bus.vout === 1'b1) begin
      if (q.size() == 0) begin
        check("spurious_vout", 1, 0);
      end else begin
        t = q.pop_front();
        check("e", bus.e, t.e);
        check("frame_start", bus.frame_start, t.fs);
      end
    end else if (bus.frame_start === 1'b1) begin
      check("fs_without_vout", 1, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.x = '0;
    bus.v = 1'b0;
    bus.done = 1'b0;
    set_coef(0, 0);
    bus.done = 1'b0;
    do_reset();

    phase = "t1";
    send(1000, 1000);
    check("lat0", bus.vout, 0);
    idle();
    check("lat1", bus.vout, 0);
    idle();
    check("lat2", bus.vout, 0);
    idle();
    check("lat3", bus.vout, 1);
    for (int n = 1; n < 20; n++) send(1000, 1000);
    drain();

    phase = "t2";
    do_reset();
    for (int n = 0; n < 32; n++) begin
      if (n == 10) begin
        check("pend_n10", bus.coef_pending, 0);
        set_coef(4096, -4096);
      end
      if (n == 11) check("pend_n11", bus.coef_pending, 1);
      if (n == 16) check("pend_n16", bus.coef_pending, 1);
      if (n == 17) check("pend_n17", bus.coef_pending, 0);
      send(100 * n, (n < 16) ? 100 * n : 100);
    end
    drain();

    phase = "t3";
    do_reset();
    set_coef(32767, 0);
    idle();
    check("pend_load", bus.coef_pending, 1);
    send(32767, 32767);
    check("pend_swap", bus.coef_pending, 0);
    send(-32768, -32768);
    send(0, 0);
    send(-1, -8);
    drain();

    phase = "t4";
    do_reset();
    set_coef(2048, 0);
    idle();
    send(3, 2);
    send(-3, -1);
    send(1, 1);
    send(-1, 0);
    drain();

    phase = "t5";
    do_reset();
    set_coef(4096, -4096);
    idle();
    set_coef(4096, 4096);
    idle();
    check("pend_two", bus.coef_pending, 1);
    for (int n = 0; n < 34; n++) begin
      if (n == 14) set_coef(12288, 0);
      if (n == 16) set_coef(4096, -4096);
      send(10, (n == 0) ? 10 : (n < 16) ? 20 :
               (n < 32) ? 30 : 0);
      if (n == 16) check("pend_defer", bus.coef_pending, 1);
      if (n == 32) check("pend_clear", bus.coef_pending, 0);
    end
    drain();

    phase = "t6";
    do_reset();
    set_coef(4096, -4096);
    idle();
    for (int n = 0; n < 20; n++) begin
      send(100 * n, (n == 0) ? 0 : 100);
      idle();
    end
    drain();
    send(50, 50 - 1900);
    for (int n = 1; n < 6; n++) begin
      if (n == 5) set_coef(12288, 0);
      send(50, 0);
    end
    do_reset();
    send(7, 7);
    send(7, 7);
    send(-9, -9);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
